// File: rtl/mage_pkg.sv
// -----------------------------------------------------------------------------
// mage_pkg
// Shared types and constants for the AGE loop sequencer slice.
//   AGE_PIPE_DEPTH  : AGE pipeline depth; default drain length of the sequencer.
//   lp_iv_vec_t     : IV vector for the default 3-loop, 8-bit configuration.
//   age_seq_state_t : sequencer FSM state encoding (IDLE/RUN/DRAIN/DONE).
// No ports (package).
// -----------------------------------------------------------------------------
package mage_pkg;

  localparam int AGE_PIPE_DEPTH = 2;
  localparam int AGE_N_LOOPS    = 3;
  localparam int AGE_NBIT_LP_IV = 8;

  typedef logic [AGE_N_LOOPS-1:0][AGE_NBIT_LP_IV-1:0] lp_iv_vec_t;

  typedef logic [1:0] age_seq_state_t;
  localparam age_seq_state_t SEQ_IDLE  = 2'd0;
  localparam age_seq_state_t SEQ_RUN   = 2'd1;
  localparam age_seq_state_t SEQ_DRAIN = 2'd2;
  localparam age_seq_state_t SEQ_DONE  = 2'd3;

endpackage

// File: rtl/age_loop_sequencer_if.sv
// -----------------------------------------------------------------------------
// age_loop_sequencer_if
// Bundles the configuration/control inputs and the AGE-facing outputs of the
// loop sequencer.
//   master : CSR / driver side (drives start, stall, bounds; observes outputs)
//   slave  : sequencer side
// Optional macro MAGE_AGE_SEQ_STRIDE_EN adds lp_step_i (per-loop IV step).
// -----------------------------------------------------------------------------
interface age_loop_sequencer_if #(
  parameter int N_LOOPS    = 3,
  parameter int NBIT_LP_IV = 8
);
  logic                          start_i;
  logic                          stall_i;
  logic [N_LOOPS*NBIT_LP_IV-1:0] lp_bound_i;
`ifdef MAGE_AGE_SEQ_STRIDE_EN
  logic [N_LOOPS*NBIT_LP_IV-1:0] lp_step_i;
`endif
  logic [N_LOOPS*NBIT_LP_IV-1:0] iv_o;
  logic                          valid_o;
  logic                          acc_reset_o;
  logic                          active_o;
  logic                          end_lp_o;
  logic                          done_o;
  logic                          busy_o;

  modport master (
`ifdef MAGE_AGE_SEQ_STRIDE_EN
    output lp_step_i,
`endif
    output start_i, stall_i, lp_bound_i,
    input  iv_o, valid_o, acc_reset_o, active_o, end_lp_o, done_o, busy_o
  );

  modport slave (
`ifdef MAGE_AGE_SEQ_STRIDE_EN
    input  lp_step_i,
`endif
    input  start_i, stall_i, lp_bound_i,
    output iv_o, valid_o, acc_reset_o, active_o, end_lp_o, done_o, busy_o
  );
endinterface

// File: rtl/age_iv_counter.sv
// -----------------------------------------------------------------------------
// age_iv_counter
// One loop induction-variable counter, chained odometer-style.
//   clk_i, rst_n_i : clock, asynchronous active-low reset
//   clr_i          : force IV to 0 (kernel start)
//   en_i           : an iteration is issued this cycle
//   carry_i        : lower loops wrapped (tie high for innermost loop)
//   bound_i        : last IV value (inclusive)
//   step_i         : IV increment (non-zero)
//   iv_o           : current IV
//   carry_o        : this loop wraps on the current advance
// -----------------------------------------------------------------------------
module age_iv_counter #(
  parameter int NBIT_LP_IV = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  clr_i,
  input  logic                  en_i,
  input  logic                  carry_i,
  input  logic [NBIT_LP_IV-1:0] bound_i,
  input  logic [NBIT_LP_IV-1:0] step_i,
  output logic [NBIT_LP_IV-1:0] iv_o,
  output logic                  carry_o
);
  logic [NBIT_LP_IV-1:0] iv_q, iv_d;
  logic [NBIT_LP_IV:0]   sum;
  logic                  wrap;

  // One extra bit so iv+step can never alias back below the bound.
  assign sum     = {1'b0, iv_q} + {1'b0, step_i};
  assign wrap    = sum > {1'b0, bound_i};
  assign carry_o = carry_i & wrap;
  assign iv_o    = iv_q;

  always_comb begin
    iv_d = iv_q;
    if (clr_i)
      iv_d = '0;
    else if (en_i && carry_i)
      iv_d = wrap ? '0 : sum[NBIT_LP_IV-1:0];
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) iv_q <= '0;
    else          iv_q <= iv_d;
  end
endmodule

// File: rtl/age_loop_sequencer.sv
// -----------------------------------------------------------------------------
// age_loop_sequencer
// Nested-loop controller feeding one AGE instance. On start it latches the
// per-loop bounds and issues one iteration per unstalled cycle, then keeps
// active high for DRAIN_CYCLES while the AGE pipeline empties, pulses end_lp
// on the first drain cycle and done once draining completes.
//   clk_i, rst_n_i : clock, asynchronous active-low reset
//   bus (slave)    : start_i, stall_i, lp_bound_i [, lp_step_i] in;
//                    iv_o, valid_o, acc_reset_o, active_o, end_lp_o, done_o,
//                    busy_o out
// Optional macro MAGE_AGE_SEQ_STRIDE_EN: per-loop step latched at start
// (step 0 behaves as 1); otherwise every loop steps by 1.
// -----------------------------------------------------------------------------
module age_loop_sequencer
  import mage_pkg::*;
#(
  parameter int N_LOOPS      = 3,
  parameter int NBIT_LP_IV   = 8,
  parameter int DRAIN_CYCLES = AGE_PIPE_DEPTH
) (
  input logic                 clk_i,
  input logic                 rst_n_i,
  age_loop_sequencer_if.slave bus
);
  localparam int DCNT_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  typedef logic [N_LOOPS-1:0][NBIT_LP_IV-1:0] iv_vec_t;

  age_seq_state_t    state_q, state_d;
  iv_vec_t           bound_q, bound_d;
  iv_vec_t           step_eff;
  iv_vec_t           iv;
  logic [DCNT_W-1:0] drain_q, drain_d;
  logic              end_lp_q, end_lp_d;
  logic [N_LOOPS-1:0] carry;
  logic              kick, issue, last_iter;

  assign kick      = (state_q == SEQ_IDLE) && bus.start_i;
  assign issue     = (state_q == SEQ_RUN) && !bus.stall_i;
  // Outermost carry-out means every loop sits at its final value.
  assign last_iter = issue && carry[N_LOOPS-1];
  assign bound_d   = kick ? iv_vec_t'(bus.lp_bound_i) : bound_q;

`ifdef MAGE_AGE_SEQ_STRIDE_EN
  iv_vec_t step_q, step_d;

  always_comb begin
    step_d = step_q;
    if (kick) begin
      for (int k = 0; k < N_LOOPS; k++) begin
        step_d[k] = bus.lp_step_i[k*NBIT_LP_IV +: NBIT_LP_IV];
        if (step_d[k] == '0) step_d[k] = NBIT_LP_IV'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) step_q <= '0;
    else          step_q <= step_d;
  end

  assign step_eff = step_q;
`else
  assign step_eff = {N_LOOPS{NBIT_LP_IV'(1)}};
`endif

  for (genvar k = 0; k < N_LOOPS; k++) begin : g_lp
    logic cin;
    if (k == 0) begin : g_inner
      assign cin = 1'b1;
    end else begin : g_outer
      assign cin = carry[k-1];
    end

    age_iv_counter #(.NBIT_LP_IV(NBIT_LP_IV)) u_cnt (
      .clk_i   (clk_i),
      .rst_n_i (rst_n_i),
      .clr_i   (kick),
      .en_i    (issue),
      .carry_i (cin),
      .bound_i (bound_q[k]),
      .step_i  (step_eff[k]),
      .iv_o    (iv[k]),
      .carry_o (carry[k])
    );
  end

  always_comb begin
    state_d  = state_q;
    drain_d  = drain_q;
    end_lp_d = 1'b0;
    case (state_q)
      SEQ_IDLE: if (kick) state_d = SEQ_RUN;
      SEQ_RUN: begin
        if (last_iter) begin
          state_d  = SEQ_DRAIN;
          drain_d  = DCNT_W'(DRAIN_CYCLES - 1);
          end_lp_d = 1'b1;
        end
      end
      SEQ_DRAIN: begin
        if (drain_q == '0) state_d = SEQ_DONE;
        else               drain_d = drain_q - DCNT_W'(1);
      end
      SEQ_DONE: state_d = SEQ_IDLE;
      default:  state_d = SEQ_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q  <= SEQ_IDLE;
      bound_q  <= '0;
      drain_q  <= '0;
      end_lp_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      bound_q  <= bound_d;
      drain_q  <= drain_d;
      end_lp_q <= end_lp_d;
    end
  end

  assign bus.iv_o        = iv;
  assign bus.valid_o     = issue;
  // Innermost carry-out marks the last iteration of the innermost loop.
  assign bus.acc_reset_o = issue && carry[0];
  assign bus.active_o    = (state_q == SEQ_RUN) || (state_q == SEQ_DRAIN);
  assign bus.end_lp_o    = end_lp_q;
  assign bus.done_o      = (state_q == SEQ_DONE);
  assign bus.busy_o      = (state_q != SEQ_IDLE);
endmodule

// File: tb/tb_age_loop_sequencer.sv
// -----------------------------------------------------------------------------
// tb_age_loop_sequencer
// Directed testbench for age_loop_sequencer (3 loops, 8-bit IVs, drain 2).
// Flag vector order: {valid, acc_reset, active, end_lp, done, busy}.
// -----------------------------------------------------------------------------
module tb_age_loop_sequencer;
  import mage_pkg::*;

  localparam int NL = 3;
  localparam int NB = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  age_loop_sequencer_if #(.N_LOOPS(NL), .NBIT_LP_IV(NB)) bus ();

  age_loop_sequencer #(.N_LOOPS(NL), .NBIT_LP_IV(NB), .DRAIN_CYCLES(2)) dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .bus     (bus)
  );

  lp_iv_vec_t iv_obs;
  logic [5:0] flags;
  assign iv_obs = bus.iv_o;
  assign flags  = {bus.valid_o, bus.acc_reset_o, bus.active_o,
                   bus.end_lp_o, bus.done_o, bus.busy_o};

  task automatic test_reset();
    #1;
    n_checks++;
    if (flags !== 6'b000000 || iv_obs !== '0) begin
      n_fail++;
      $display("FAIL reset_async flags=%b iv=%h expected flags=000000 iv=0", flags, iv_obs);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_checks++;
    if (flags !== 6'b000000 || iv_obs !== '0) begin
      n_fail++;
      $display("FAIL reset_release flags=%b iv=%h expected flags=000000 iv=0", flags, iv_obs);
    end
  endtask

  // Bounds {0,2,1}: innermost loop runs once, so acc_reset on every valid.
  task automatic test_basic();
    logic [7:0] e1 [6] = '{8'd0, 8'd1, 8'd2, 8'd0, 8'd1, 8'd2};
    logic [7:0] e2 [6] = '{8'd0, 8'd0, 8'd0, 8'd1, 8'd1, 8'd1};
    logic [5:0] tail [4] = '{6'b001101, 6'b001001, 6'b000011, 6'b000000};
    @(negedge clk);
    bus.lp_bound_i = {8'd1, 8'd2, 8'd0};
    bus.start_i    = 1'b1;
    #1;
    n_checks++;
    if (flags !== 6'b000000) begin
      n_fail++;
      $display("FAIL basic_idle flags=%b expected 000000", flags);
    end
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      bus.start_i = 1'b0;
      #1;
      n_checks++;
      if (flags !== 6'b111001 || iv_obs !== {e2[i], e1[i], 8'd0}) begin
        n_fail++;
        $display("FAIL basic_run[%0d] flags=%b iv=%h expected flags=111001 iv=%h",
                 i, flags, iv_obs, {e2[i], e1[i], 8'd0});
      end
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      #1;
      n_checks++;
      if (flags !== tail[i]) begin
        n_fail++;
        $display("FAIL basic_tail[%0d] flags=%b expected %b", i, flags, tail[i]);
      end
    end
  endtask

  // Bounds {3,0,0} with stall on RUN cycles 2 and 3.
  task automatic test_stall();
    logic       st [6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    logic [7:0] e0 [6] = '{8'd0, 8'd1, 8'd1, 8'd1, 8'd2, 8'd3};
    logic [5:0] ef [6] = '{6'b101001, 6'b001001, 6'b001001,
                           6'b101001, 6'b101001, 6'b111001};
    @(negedge clk);
    bus.lp_bound_i = {8'd0, 8'd0, 8'd3};
    bus.start_i    = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      bus.start_i = 1'b0;
      bus.stall_i = st[i];
      #1;
      n_checks++;
      if (flags !== ef[i] || iv_obs !== {8'd0, 8'd0, e0[i]}) begin
        n_fail++;
        $display("FAIL stall_run[%0d] flags=%b iv=%h expected flags=%b iv0=%0d",
                 i, flags, iv_obs, ef[i], e0[i]);
      end
    end
    @(negedge clk);
    bus.stall_i = 1'b1;  // ignored while draining
    #1;
    n_checks++;
    if (flags !== 6'b001101) begin
      n_fail++;
      $display("FAIL stall_end_lp flags=%b expected 001101", flags);
    end
    repeat (3) @(negedge clk);
    bus.stall_i = 1'b0;
    #1;
    n_checks++;
    if (flags !== 6'b000000) begin
      n_fail++;
      $display("FAIL stall_back_idle flags=%b expected 000000", flags);
    end
  endtask

  // All bounds 0: single valid with acc_reset, active for three cycles.
  task automatic test_all_zero();
    logic [5:0] ef [5] = '{6'b111001, 6'b001101, 6'b001001, 6'b000011, 6'b000000};
    int n_active = 0;
    @(negedge clk);
    bus.lp_bound_i = '0;
    bus.start_i    = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      bus.start_i = 1'b0;
      #1;
      if (bus.active_o) n_active++;
      n_checks++;
      if (flags !== ef[i]) begin
        n_fail++;
        $display("FAIL zero_seq[%0d] flags=%b expected %b", i, flags, ef[i]);
      end
    end
    n_checks++;
    if (n_active !== 3) begin
      n_fail++;
      $display("FAIL zero_active_cycles got %0d expected 3", n_active);
    end
  endtask

  // Runs one {0,2,1} kernel (optionally re-pulsing start mid-run) and counts.
  task automatic run_and_count(input bit repulse, output int n_valid,
                               output int n_end, output int n_done,
                               output lp_iv_vec_t last_iv);
    n_valid = 0; n_end = 0; n_done = 0; last_iv = '0;
    @(negedge clk);
    bus.lp_bound_i = {8'd1, 8'd2, 8'd0};
    bus.start_i    = 1'b1;
    for (int c = 0; c < 40 && n_done == 0; c++) begin
      @(negedge clk);
      bus.start_i = 1'b0;
      if (repulse && c == 2) begin
        bus.start_i    = 1'b1;
        bus.lp_bound_i = {8'd3, 8'd3, 8'd3};
      end
      #1;
      if (bus.valid_o) begin
        n_valid++;
        last_iv = iv_obs;
      end
      if (bus.end_lp_o) n_end++;
      if (bus.done_o)   n_done++;
    end
    @(negedge clk);
    bus.start_i = 1'b0;
  endtask

  task automatic test_restart_ignored();
    int n_valid, n_end, n_done;
    lp_iv_vec_t last_iv;
    run_and_count(1'b1, n_valid, n_end, n_done, last_iv);
    n_checks++;
    if (n_valid !== 6 || n_end !== 1 || n_done !== 1 || last_iv !== {8'd1, 8'd2, 8'd0}) begin
      n_fail++;
      $display("FAIL restart_ignored valid=%0d end=%0d done=%0d last_iv=%h expected 6/1/1/010200",
               n_valid, n_end, n_done, last_iv);
    end
  endtask

  task automatic test_async_reset();
    int n_valid, n_end, n_done;
    lp_iv_vec_t last_iv;
    @(negedge clk);
    bus.lp_bound_i = {8'd0, 8'd0, 8'd3};
    bus.start_i    = 1'b1;
    repeat (2) begin
      @(negedge clk);
      bus.start_i = 1'b0;
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (flags !== 6'b000000 || iv_obs !== '0) begin
      n_fail++;
      $display("FAIL async_reset flags=%b iv=%h expected flags=000000 iv=0", flags, iv_obs);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    n_checks++;
    if (flags !== 6'b000000) begin
      n_fail++;
      $display("FAIL async_reset_after flags=%b expected 000000", flags);
    end
    run_and_count(1'b0, n_valid, n_end, n_done, last_iv);
    n_checks++;
    if (n_valid !== 6 || n_end !== 1 || n_done !== 1 || last_iv !== {8'd1, 8'd2, 8'd0}) begin
      n_fail++;
      $display("FAIL async_reset_rerun valid=%0d end=%0d done=%0d last_iv=%h expected 6/1/1/010200",
               n_valid, n_end, n_done, last_iv);
    end
  endtask

`ifdef MAGE_AGE_SEQ_STRIDE_EN
  // Bounds {7,0,0}, step {3,1,1}: iv0 = 0,3,6 then wrap.
  task automatic test_stride();
    logic [7:0] e0 [3] = '{8'd0, 8'd3, 8'd6};
    logic [5:0] ef [4] = '{6'b101001, 6'b101001, 6'b111001, 6'b001101};
    @(negedge clk);
    bus.lp_bound_i = {8'd0, 8'd0, 8'd7};
    bus.lp_step_i  = {8'd1, 8'd1, 8'd3};
    bus.start_i    = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bus.start_i = 1'b0;
      #1;
      n_checks++;
      if (flags !== ef[i] || (i < 3 && iv_obs !== {8'd0, 8'd0, e0[i]})) begin
        n_fail++;
        $display("FAIL stride[%0d] flags=%b iv=%h expected flags=%b", i, flags, iv_obs, ef[i]);
      end
    end
    repeat (3) @(negedge clk);
    bus.lp_step_i = '0;
  endtask
`endif

  initial begin
    bus.start_i    = 1'b0;
    bus.stall_i    = 1'b0;
    bus.lp_bound_i = '0;
`ifdef MAGE_AGE_SEQ_STRIDE_EN
    bus.lp_step_i  = '0;
`endif
    test_reset();
    test_basic();
    test_stall();
    test_all_zero();
    test_restart_ignored();
    test_async_reset();
`ifdef MAGE_AGE_SEQ_STRIDE_EN
    test_stride();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/age_loop_sequencer.md
Name: age_loop_sequencer

Overview:
- Nested-loop controller that drives one AGE instance.
- Configured with per-loop bounds; on a start pulse it steps the loop induction variables (IVs) through every iteration, one per cycle, and emits per-cycle valid and accumulation-reset markers.
- After the last iteration it holds active high while the 2-stage AGE pipeline drains, pulses end-of-loop, then reports done.
- Sits between the configuration CSRs and the AGE ivs/valid/active/end_lp/pea_acc_reset inputs.

Parameters:
- N_LOOPS, 3, number of nested loops; index 0 is innermost.
- NBIT_LP_IV, 8, width of each IV and bound.
- DRAIN_CYCLES, 2, cycles active stays high after the last valid iteration (matches AGE pipeline depth).

Ports:
- clk_i  in  1  clock.
- rst_n_i  in  1  asynchronous active-low reset.
- start_i  in  1  one-cycle pulse; latches bounds and begins a kernel.
- stall_i  in  1  backpressure; freezes iteration.
- lp_bound_i  in  N_LOOPS*NBIT_LP_IV  last IV value per loop (inclusive).
- iv_o  out  N_LOOPS*NBIT_LP_IV  current IVs.
- valid_o  out  1  iv_o is a real iteration this cycle.
- acc_reset_o  out  1  this iteration is the last of the innermost loop.
- active_o  out  1  kernel in progress, including drain.
- end_lp_o  out  1  one-cycle pulse after the last valid iteration.
- done_o  out  1  one-cycle pulse when drain completes.
- busy_o  out  1  state != IDLE.

Behaviour:
- Reset: all outputs 0, state IDLE, IV counters 0, bound registers 0.
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - On start_i: latch lp_bound_i, clear IVs, go to RUN next cycle.
  - First valid_o appears in the first RUN cycle, so latency from start_i to first valid is 1 cycle.
- RUN, per cycle:
  - If stall_i=1: valid_o=0, IVs hold.
  - Otherwise: valid_o=1 with the current IVs, then advance odometer-style. iv[0]++; when iv[k]==bound[k] it wraps to 0 and carries into iv[k+1].
  - acc_reset_o=valid_o & (iv[0]==bound[0]).
  - Last iteration is the cycle in which all iv[k]==bound[k] and stall_i=0. The next state is DRAIN and end_lp_o pulses in that next cycle.
  - stall_i is sampled the same cycle and has no latency.
- DRAIN:
  - Down-counter loaded with DRAIN_CYCLES-1; valid_o=0, active_o=1.
  - stall_i ignored.
  - When the counter reaches 0, go to DONE.
- DONE: done_o=1 for one cycle, active_o=0, then IDLE.
- active_o is 1 in RUN and DRAIN only.
- Bound of 0 on a loop: that loop runs exactly 1 iteration. All bounds 0: one valid cycle, acc_reset_o=1.
- Total valid cycles = product over k of (bound[k]+1). No overflow, since IV counters never exceed their bound.
- start_i while busy_o=1 is ignored; config changes mid-kernel have no effect.
- Asynchronous reset mid-kernel returns to IDLE immediately; no end_lp_o or done_o is generated.
- stall_i asserted on the last iteration delays the DRAIN transition until the iteration is actually issued.

Optional Feature:
- Macro: MAGE_AGE_SEQ_STRIDE_EN.
- When defined:
  - Adds input lp_step_i (N_LOOPS*NBIT_LP_IV, latched at start).
  - iv[k] advances by step[k].
  - Wrap condition becomes iv[k]+step[k] > bound[k]. The comparison uses NBIT_LP_IV+1 bits, so no wrap-around aliasing.
  - A step of 0 is treated as 1.
- When undefined: port absent, step fixed to 1, and behaviour is identical to the description above.

Decomposition:
- mage_pkg gains:
  - typedef age_seq_state_t (IDLE/RUN/DRAIN/DONE).
  - constant AGE_PIPE_DEPTH=2, used as the DRAIN_CYCLES default.
  - typedef lp_iv_vec_t for the N_LOOPS IV vector.
- One natural sub-module: age_iv_counter. It holds a single loop counter with enable, bound, step, carry-in and carry-out, and is instantiated N_LOOPS times in a carry chain.

Test Plan:
- N_LOOPS=3 for all scenarios below.
- Bounds {0,2,1} (loop0..2), start, no stall -> 6 valid cycles:
  - iv1/iv2 sequence (0,0),(1,0),(2,0),(0,1),(1,1),(2,1), with iv0 constant 0.
  - acc_reset_o high on every valid cycle.
  - end_lp_o the cycle after the 6th valid, done_o 2 cycles later.
- Bounds {3,0,0}, stall_i high on the 2nd and 3rd RUN cycles:
  - valid sequence iv0=0,-,-,1,2,3 (- = valid_o low, IVs frozen).
  - acc_reset_o only with iv0=3.
- All bounds 0 -> exactly one valid cycle with acc_reset_o=1; active_o high for 3 cycles total.
- start_i re-pulsed during RUN with different bounds -> ignored; iteration count unchanged (6 for bounds {0,2,1}).
- rst_n_i low mid-RUN -> all outputs 0 asynchronously; after release, a new start yields a full, correct sequence.
- With MAGE_AGE_SEQ_STRIDE_EN, bounds {7,0,0}, step {3,1,1} -> iv0 = 0,3,6, then wrap; 3 valid cycles.
